uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter between `NUM_REQ` byte producers. Each requester offers a byte over a valid/ready handshake. The arbiter grants one requester, launches the transmitter with a one-cycle `tx_start` and the latched byte, then waits for the transmitter's `tx_done` pulse. A watchdog aborts the transfer if `tx_done` never arrives. It sits between the command/telemetry producers and the existing serial transmitter.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_arb_if.sv | 22 ++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arb.sv | 91 +++++++++
 tb/tb_uart_tx_arb.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART arbiter definitions: FSM encodings, default watchdog
// limit and a constant-friendly clog2.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2
   } state_t;

   localparam int TIMEOUT_DEF = 512;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Request handshake plus transmitter launch/done signals
// shared between the producers, the arbiter and the UART.
interface uart_tx_arb_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic                 tx_done;

   modport master (
      output req_valid, req_data, tx_done,
      input  req_ready, tx_start, tx_data
   );

   modport slave (
      input  req_valid, req_data, tx_done,
      output req_ready, tx_start, tx_data
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or
// after the pointer, wrapping around.
module rr_pick
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic               any,
   output logic [IDW-1:0]     idx
);

   int j;

   // Scan from the far end so the closest slot to ptr wins.
   always_comb begin
      any = |req;
      idx = '0;
      j   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j > NUM_REQ - 1) j = j - NUM_REQ;
         if (req[j]) idx = IDW'(j);
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin sequencer sharing one UART transmitter between
// several byte producers, with a watchdog on tx_done.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int TIMEOUT_CYC = TIMEOUT_DEF,
   localparam int IDW         = clog2(NUM_REQ)
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_arb_if.slave   bus,
   output logic           busy,
   output logic           xfer_done,
   output logic [IDW-1:0] xfer_id,
   output logic           timeout_err
);

   localparam int TOW = clog2(TIMEOUT_CYC);
   localparam logic [TOW-1:0] WD_LAST = TOW'(TIMEOUT_CYC - 1);
   localparam logic [IDW-1:0] ID_LAST = IDW'(NUM_REQ - 1);

   state_t         state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] nxt_ptr;
   logic [TOW-1:0] wd_cnt;
   logic           pick_any;
   logic [IDW-1:0] pick_idx;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign nxt_ptr = (xfer_id == ID_LAST) ? '0 : xfer_id + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         wd_cnt        <= '0;
         bus.tx_start  <= 1'b0;
         bus.tx_data   <= '0;
         bus.req_ready <= '0;
         busy          <= 1'b0;
         xfer_done     <= 1'b0;
         xfer_id       <= '0;
         timeout_err   <= 1'b0;
      end else begin
         xfer_done   <= 1'b0;
         timeout_err <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  bus.tx_data   <= bus.req_data[8*pick_idx +: 8];
                  bus.req_ready <= NUM_REQ'(1) << pick_idx;
                  bus.tx_start  <= 1'b1;
                  xfer_id       <= pick_idx;
                  busy          <= 1'b1;
                  state         <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               bus.tx_start  <= 1'b0;
               bus.req_ready <= '0;
               wd_cnt        <= '0;
               state         <= ST_BUSY;
            end
            ST_BUSY: begin
               wd_cnt <= wd_cnt + 1'b1;
               // A done on the expiry cycle still counts as success.
               if (bus.tx_done) begin
                  xfer_done <= 1'b1;
                  busy      <= 1'b0;
                  ptr       <= nxt_ptr;
                  state     <= ST_IDLE;
               end else if (wd_cnt == WD_LAST) begin
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
                  ptr         <= nxt_ptr;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arb;
   import uart_pkg::*;

   localparam int NR = 4;
   localparam int TO = 512;
   localparam int IW = clog2(NR);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          busy;
   logic          xfer_done;
   logic [IW-1:0] xfer_id;
   logic          timeout_err;

   uart_tx_arb_if #(.NUM_REQ(NR)) bus ();

   uart_tx_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .busy        (busy),
      .xfer_done   (xfer_done),
      .xfer_id     (xfer_id),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tot  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   // Model: a transfer is "active" from grant until done/abort;
   // age counts edges since the grant edge.
   logic          m_live = 1'b0;
   logic          m_act  = 1'b0;
   int            m_age  = 0;
   int            m_ptr  = 0;
   int            m_g    = 0;
   logic          e_start = 1'b0;
   logic [NR-1:0] e_ready = '0;
   logic [7:0]    e_data  = '0;
   logic          e_busy  = 1'b0;
   logic          e_xdone = 1'b0;
   logic [IW-1:0] e_id    = '0;
   logic          e_terr  = 1'b0;

   always @(posedge clk) begin : model
      int  g;
      bit  found;
      m_live  <= 1'b1;
      e_start <= 1'b0;
      e_ready <= '0;
      e_xdone <= 1'b0;
      e_terr  <= 1'b0;
      if (!rst_n) begin
         m_act  <= 1'b0;
         m_age  <= 0;
         m_ptr  <= 0;
         e_data <= '0;
         e_id   <= '0;
         e_busy <= 1'b0;
      end else if (!m_act) begin
         found = 1'b0;
         g     = 0;
         for (int k = 0; k < NR; k++)
            if (!found && bus.req_valid[(m_ptr + k) % NR]) begin
               found = 1'b1;
               g     = (m_ptr + k) % NR;
            end
         if (found) begin
            e_start <= 1'b1;
            e_ready <= NR'(1) << g;
            e_data  <= bus.req_data[8*g +: 8];
            e_id    <= IW'(g);
            e_busy  <= 1'b1;
            m_act   <= 1'b1;
            m_age   <= 1;
            m_g     <= g;
         end
      end else begin
         m_age <= m_age + 1;
         if (m_age >= 2 && bus.tx_done) begin
            e_xdone <= 1'b1;
            e_busy  <= 1'b0;
            m_act   <= 1'b0;
            m_ptr   <= (m_g + 1) % NR;
         end else if (m_age == TO + 1) begin
            e_terr <= 1'b1;
            e_busy <= 1'b0;
            m_act  <= 1'b0;
            m_ptr  <= (m_g + 1) % NR;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("tx_start", int'(bus.tx_start), int'(e_start));
         chk("req_ready", int'(bus.req_ready), int'(e_ready));
         chk("tx_data", int'(bus.tx_data), int'(e_data));
         chk("busy", int'(busy), int'(e_busy));
         chk("xfer_done", int'(xfer_done), int'(e_xdone));
         chk("xfer_id", int'(xfer_id), int'(e_id));
         chk("timeout_err", int'(timeout_err), int'(e_terr));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_start(input string nm, output int c);
      int n;
      n = 0;
      while (!bus.tx_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_start_seen"}, int'(bus.tx_start), 1);
      c = cyc;
   endtask

   task automatic done_pulse();
      bus.tx_done = 1'b1;
      tick(1);
      bus.tx_done = 1'b0;
   endtask

   initial begin
      int c;
      int t_done;
      int n;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_done   = 1'b0;
      rst_n = 1'b0;
      tick(3);
      chk("rst_start", int'(bus.tx_start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_data", int'(bus.tx_data), 0);
      chk("rst_id", int'(xfer_id), 0);
      rst_n = 1'b1;

      // single request on slot 2
      bus.req_data  = 32'h00A5_0000;
      bus.req_valid = 4'b0100;
      wait_start("single", c);
      chk("single_data", int'(bus.tx_data), 'hA5);
      chk("single_ready", int'(bus.req_ready), 4);
      chk("single_id", int'(xfer_id), 2);
      bus.req_valid = '0;
      tick(300);
      done_pulse();
      chk("single_xdone", int'(xfer_done), 1);
      chk("single_busy", int'(busy), 0);

      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;

      // all four valid: rotate 0,1,2,3,0
      bus.req_data  = 32'h1312_1110;
      bus.req_valid = 4'hF;
      t_done = 0;
      for (int k = 0; k < 5; k++) begin
         wait_start("rr", c);
         chk("rr_id", int'(xfer_id), k % 4);
         chk("rr_data", int'(bus.tx_data), 'h10 + k % 4);
         if (k > 0) chk("rr_gap", c - t_done, 2);
         if (k == 4) bus.req_valid = '0;
         tick(320);
         t_done = cyc;
         done_pulse();
      end

      // pointer at 1: slot 3 beats slot 0
      bus.req_data  = 32'h2300_0020;
      bus.req_valid = 4'b1001;
      wait_start("skip", c);
      chk("skip_id0", int'(xfer_id), 3);
      chk("skip_data0", int'(bus.tx_data), 'h23);
      bus.req_valid = 4'b0001;
      tick(10);
      done_pulse();
      wait_start("skip", c);
      chk("skip_id1", int'(xfer_id), 0);
      chk("skip_data1", int'(bus.tx_data), 'h20);
      bus.req_valid = '0;
      tick(10);
      done_pulse();

      // watchdog abort on slot 1
      bus.req_data  = 32'h0000_3100;
      bus.req_valid = 4'b0010;
      wait_start("to", c);
      chk("to_id", int'(xfer_id), 1);
      bus.req_valid = '0;
      n = 0;
      while (!timeout_err && n < 600) begin
         tick(1);
         n++;
      end
      chk("to_seen", int'(timeout_err), 1);
      chk("to_lat", cyc - (c + 1), 512);
      chk("to_busy", int'(busy), 0);

      // pointer now 2; done on the expiry cycle
      bus.req_data  = 32'h0042_0040;
      bus.req_valid = 4'b0101;
      wait_start("tie", c);
      chk("tie_id", int'(xfer_id), 2);
      bus.req_valid = '0;
      tick(512);
      done_pulse();
      chk("tie_xdone", int'(xfer_done), 1);
      chk("tie_terr", int'(timeout_err), 0);

      // reset in BUSY, pending request re-granted from pointer 0
      bus.req_data  = 32'h4300_0040;
      bus.req_valid = 4'b1000;
      wait_start("rst", c);
      chk("rst_id3", int'(xfer_id), 3);
      bus.req_valid = 4'b1001;
      tick(20);
      rst_n = 1'b0;
      tick(1);
      chk("mid_rst_start", int'(bus.tx_start), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_data", int'(bus.tx_data), 0);
      chk("mid_rst_id", int'(xfer_id), 0);
      chk("mid_rst_ready", int'(bus.req_ready), 0);
      rst_n = 1'b1;
      wait_start("regrant", c);
      chk("regrant_id", int'(xfer_id), 0);
      chk("regrant_data", int'(bus.tx_data), 'h40);
      bus.req_valid = '0;
      tick(5);
      done_pulse();
      tick(3);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
